// File: rtl/serial_echo_fifo.sv
// Serial echo buffer: received bytes are queued, offset by a constant and replayed
// to the transmitter one at a time under host flow control.
module serial_echo_fifo #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] ADD_VALUE  = 8'd1,
  parameter int         CTS_MARGIN = 4,
  parameter int         CNT_W      = 3
) (
  input  logic                  clk100,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rbyte_ready,
  input  logic                  host_rts_n,
  input  logic                  clear_ovf,
  input  logic                  tx_busy,
  output logic [7:0]            tx_byte,
  output logic                  tx_send,
  output logic                  cts_n,
  output logic                  overflow,
  output logic [CNT_W-1:0]      rx_count,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE      = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ZERO     = LVL_W'(0);
  localparam logic [LVL_W-1:0] FULL_LEVEL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] MARGIN_LEVEL = LVL_W'(CTS_MARGIN);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_GUARD     = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [1:0]       state_r;
  logic             guard_r;
  logic [7:0]       tx_byte_r;
  logic             tx_send_r;
  logic             cts_n_r;
  logic             overflow_r;
  logic [CNT_W-1:0] rx_count_r;

  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [LVL_W-1:0] level_next_s;
  logic [LVL_W-1:0] free_next_s;
  logic [1:0]       state_next_s;

  // Push/pop decisions; a pop frees the full slot in the same cycle, so push is still legal.
  always_comb begin
    full_s = (level_r == FULL_LEVEL);
    pop_s  = (state_r == ST_IDLE) && (level_r != LVL_ZERO) && !host_rts_n && !tx_busy;
    if (rbyte_ready) begin
      push_s = !full_s || pop_s;
    end else begin
      push_s = 1'b0;
    end
    drop_s = rbyte_ready && !push_s;
  end

  // Next occupancy and the free-slot count that drives flow control.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
    free_next_s = FULL_LEVEL - level_next_s;
  end

  // Transmit sequencer next-state; GUARD spans two cycles while tx_busy rises.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_next_s = ST_SEND;
        else       state_next_s = ST_IDLE;
      end
      ST_SEND:  state_next_s = ST_GUARD;
      ST_GUARD: begin
        if (guard_r) state_next_s = ST_WAIT_DONE;
        else         state_next_s = ST_GUARD;
      end
      ST_WAIT_DONE: begin
        if (tx_busy) state_next_s = ST_WAIT_DONE;
        else         state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk100) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= rx_byte;
    end
  end

  // Pointers, occupancy, flags and counters.
  always_ff @(posedge clk100) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= LVL_ZERO;
      cts_n_r    <= 1'b0;
      overflow_r <= 1'b0;
      rx_count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      level_r <= level_next_s;
      cts_n_r <= (free_next_s <= MARGIN_LEVEL);
      // A drop wins over a coincident clear so no overflow event is lost.
      if (drop_s)         overflow_r <= 1'b1;
      else if (clear_ovf) overflow_r <= 1'b0;
      if (rbyte_ready) rx_count_r <= rx_count_r + CNT_ONE;
    end
  end

  // Transmit sequencer state and registered transmitter interface.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      guard_r   <= 1'b0;
      tx_byte_r <= 8'h00;
      tx_send_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_GUARD) guard_r <= ~guard_r;
      else                     guard_r <= 1'b0;
      if (pop_s) tx_byte_r <= mem_r[rd_ptr_r] + ADD_VALUE;
      tx_send_r <= pop_s;
    end
  end

  assign tx_byte    = tx_byte_r;
  assign tx_send    = tx_send_r;
  assign cts_n      = cts_n_r;
  assign overflow   = overflow_r;
  assign rx_count   = rx_count_r;
  assign fifo_level = level_r;

endmodule

// File: doc/serial_echo_fifo.md
SERIAL_ECHO_FIFO -- requirements
Module: serial_echo_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (legal 2..10).
REQ-002 SHALL have parameter ADD_VALUE, default 8'd1, constant added modulo 256 to every echoed byte.
REQ-003 SHALL have parameter CTS_MARGIN, default 4, free slots at or below which flow control stops the host (legal 1..DEPTH-1).
REQ-004 SHALL have parameter CNT_W, default 3, width of received-byte counter.
REQ-005 clk100  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rx_byte  input  8  received byte from serial receiver, valid when rbyte_ready=1.
REQ-008 rbyte_ready  input  1  one-cycle strobe, byte available.
REQ-009 host_rts_n  input  1  0 = host accepts data; 1 = do not start new transmissions.
REQ-010 clear_ovf  input  1  one-cycle strobe clearing overflow.
REQ-011 tx_busy  input  1  transmitter busy flag.
REQ-012 tx_byte  output  8  byte to transmitter, registered.
REQ-013 tx_send  output  1  one-cycle start strobe to transmitter.
REQ-014 cts_n  output  1  0 = host may send; 1 = host must pause.
REQ-015 overflow  output  1  sticky, byte dropped on full FIFO.
REQ-016 rx_count  output  CNT_W  received-byte counter (LED drive), wraps.
REQ-017 fifo_level  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.

Function
REQ-018 Push: rbyte_ready=1 and FIFO not full -> rx_byte written; fifo_level reflects it the next cycle.
REQ-019 Push on full SHALL drop byte, set overflow next cycle, leave level and contents unchanged.
REQ-020 rx_count SHALL increment on every rbyte_ready, including dropped bytes, wrapping 2**CNT_W-1 -> 0.
REQ-021 Simultaneous push and pop SHALL keep fifo_level unchanged; allowed when full (pop frees slot same cycle, push accepted, no overflow).
REQ-022 Pointers SHALL wrap modulo DEPTH; full = level==DEPTH, empty = level==0.
REQ-023 TX FSM states: IDLE, SEND, GUARD, WAIT_DONE.
REQ-024 IDLE: if level!=0 and host_rts_n=0 and tx_busy=0 -> pop head, tx_byte <= head+ADD_VALUE (8-bit wrap), go SEND; else stay.
REQ-025 SEND: tx_send=1 for exactly this cycle; go GUARD.
REQ-026 GUARD: 2 cycles unconditionally (covers transmitter busy-rise latency); then WAIT_DONE.
REQ-027 WAIT_DONE: stay while tx_busy=1; go IDLE when tx_busy=0.
REQ-028 tx_send SHALL be 0 outside SEND; tx_byte SHALL hold stable from load until next pop.
REQ-029 Latency: rbyte_ready in cycle N, empty FIFO, IDLE, host_rts_n=0, tx_busy=0 -> tx_send=1 in cycle N+2.
REQ-030 host_rts_n=1 SHALL block only new pops; an in-progress transfer completes.
REQ-031 cts_n SHALL be registered: 1 when free slots (DEPTH-level) <= CTS_MARGIN, else 0, evaluated on next-cycle level.
REQ-032 overflow SHALL clear on clear_ovf; if clear_ovf and a dropping push coincide, overflow SHALL remain 1.
REQ-033 Bytes SHALL be echoed in arrival order, none duplicated.

Reset
REQ-034 reset=1 SHALL within one edge set: FSM IDLE, level 0, pointers 0, tx_byte 8'h00, tx_send 0, cts_n 0, overflow 0, rx_count 0; FIFO RAM contents need not clear.
REQ-035 reset mid-transfer SHALL abort: pending bytes discarded, no tx_send issued in cycle after reset release.

Verification
REQ-036 Single byte 8'h41, idle, host_rts_n=0, tx_busy modelled 10 cycles after send -> tx_send at N+2, tx_byte=8'h42, level back to 0.
REQ-037 Byte 8'hFF with ADD_VALUE=1 -> tx_byte=8'h00 (wrap).
REQ-038 host_rts_n=1, push 17 bytes DEPTH=16 -> level=16, overflow=1, cts_n=1 from level 12, rx_count=17 mod 8=1; release host_rts_n -> 16 bytes echoed in order, first 16 only.
REQ-039 Full FIFO, push and pop same cycle -> level stays 16, overflow stays 0, new byte echoed last.
REQ-040 clear_ovf coincident with dropping push -> overflow stays 1; clear_ovf alone next -> overflow 0.
REQ-041 reset asserted during WAIT_DONE with 5 queued bytes -> all outputs at REQ-034 values, no further tx_send until new rbyte_ready.
